bcd_to_binary_converter: RTL

//  Sequential BCD-to-binary converter; inverse of the ATM display path's binary-to-BCD stage.

---
 rtl/bcd_conv_pkg.sv | 27 ++
 rtl/bcd_digit_sub3.sv | 18 +
 rtl/bcd_to_binary_converter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// The optional input/overflow checking is enabled by defining BCD_CHECK_EN.
package bcd_conv_pkg;

    // Width of the binary result; also the number of shift iterations
    localparam int BIN_W = 8;

    // Digit field widths inside the BCD shift register
    localparam int DIGIT_W = 4;
    localparam int HUND_W  = 2;
    localparam int BCD_W   = HUND_W + 2 * DIGIT_W;

    // Reverse double-dabble correction: a digit that reached 8 after the
    // right shift received a carried-in 10 (shown as 8), so take 3 back off
    localparam logic [DIGIT_W-1:0] SUB_THRESH = 4'd8;
    localparam logic [DIGIT_W-1:0] SUB_VAL    = 4'd3;

    // Largest legal decimal digit
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_sub3.sv
// Single-digit correction for reverse double-dabble: subtract 3 from a
// 4-bit BCD digit whose value is 8 or more after the right shift.
module bcd_digit_sub3
    import bcd_conv_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    // Conditional subtract; digits below the threshold pass through
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= SUB_THRESH) begin
            digit_out = digit_in - SUB_VAL;
        end
    end

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble).
// One operand is accepted in IDLE, shifted for BIN_W cycles, then the result
// is offered with a valid/ready handshake.
// Define BCD_CHECK_EN to flag illegal digits and values above 255 on err
// (bin_out is then forced to zero); otherwise err is tied low.
module bcd_to_binary_converter
    import bcd_conv_pkg::*;
#(
    parameter int BIN_W = bcd_conv_pkg::BIN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [HUND_W-1:0]  hundreds,
    input  logic [DIGIT_W-1:0] tens,
    input  logic [DIGIT_W-1:0] ones,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIN_W-1:0]   bin_out,
    output logic               err
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   iter_cnt;
    logic [BCD_W-1:0]   bcd_sr;
    logic [BIN_W-1:0]   bin_sr;

    logic [BCD_W-1:0]   bcd_shifted;
    logic [BIN_W-1:0]   bin_next;
    logic [DIGIT_W-1:0] tens_adj;
    logic [DIGIT_W-1:0] ones_adj;
    logic [BCD_W-1:0]   bcd_next;

    logic               accept;
    logic               last_iter;
    logic               capture;
    logic               release_out;
    logic [BIN_W-1:0]   result_bin;

    // Handshake qualifiers; in_ready is held low while reset is asserted
    assign in_ready    = (state == IDLE) && rst_n;
    assign accept      = in_valid && in_ready;
    assign last_iter   = (state == SHIFT) && (iter_cnt == LAST_ITER);
    assign capture     = (state == DONE) && !out_valid;
    assign release_out = (state == DONE) && out_valid && out_ready;

    // One combined right shift: the BCD register's LSB moves into the binary MSB
    assign bcd_shifted = bcd_sr >> 1;
    assign bin_next    = {bcd_sr[0], bin_sr[BIN_W-1:1]};

    bcd_digit_sub3 u_tens_sub3 (
        .digit_in  (bcd_shifted[2*DIGIT_W-1:DIGIT_W]),
        .digit_out (tens_adj)
    );

    bcd_digit_sub3 u_ones_sub3 (
        .digit_in  (bcd_shifted[DIGIT_W-1:0]),
        .digit_out (ones_adj)
    );

    // The 2-bit hundreds digit can never reach 8, so it is never corrected
    assign bcd_next = {bcd_shifted[BCD_W-1:2*DIGIT_W], tens_adj, ones_adj};

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: IDLE -> SHIFT -> DONE -> IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)      next_state = SHIFT;
            SHIFT:   if (last_iter)   next_state = DONE;
            DONE:    if (release_out) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Shift registers and iteration counter; reset clears them so an aborted
    // operand leaves nothing behind
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_sr   <= '0;
            bin_sr   <= '0;
            iter_cnt <= '0;
        end else if (accept) begin
            bcd_sr   <= {hundreds, tens, ones};
            bin_sr   <= '0;
            iter_cnt <= '0;
        end else if (state == SHIFT) begin
            bcd_sr   <= bcd_next;
            bin_sr   <= bin_next;
            iter_cnt <= iter_cnt + 1'b1;
        end
    end

`ifdef BCD_CHECK_EN
    logic err_flag;
    logic err_reg;

    // Error flag: illegal digit at load, or BCD residue (value > 255) after the last shift
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
        end else if (accept) begin
            err_flag <= (tens > DIGIT_MAX) || (ones > DIGIT_MAX);
        end else if (last_iter && (bcd_next != '0)) begin
            err_flag <= 1'b1;
        end
    end

    // Error output is captured together with the result so it stays stable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (capture) begin
            err_reg <= err_flag;
        end
    end

    assign result_bin = err_flag ? '0 : bin_sr;
    assign err        = err_reg;
`else
    assign result_bin = bin_sr;
    assign err        = 1'b0;
`endif

    // Result register: captured on the first DONE cycle, held until the consumer takes it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            bin_out   <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            bin_out   <= result_bin;
        end else if (release_out) begin
            out_valid <= 1'b0;
        end
    end

endmodule
